// File: rtl/uart_pkg.sv
// Shared UART definitions: receiver FSM states and the 16x oversample divisor.
package uart_pkg;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_START = 2'd1,
        S_DATA  = 2'd2,
        S_STOP  = 2'd3
    } uart_state_e;

    localparam int unsigned OVERSAMPLE = 16;

    function automatic int unsigned calc_div(input int unsigned clk_freq,
                                             input int unsigned baud_rate);
        return clk_freq / (baud_rate * OVERSAMPLE);
    endfunction

endpackage

// File: rtl/baud_rate_gen.sv
// Free-running oversample tick: one-cycle pulse every DIV clocks, first at DIV-1 after reset.
// No handshake; consumers simply qualify their logic with o_tick.
module baud_rate_gen #(
    parameter int unsigned DIV = 10
) (
    input  logic clk,
    input  logic rst,
    output logic o_tick
);

    localparam int unsigned CW = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [CW-1:0] LAST = CW'(DIV - 1);

    logic [CW-1:0] cnt_q, cnt_d;

    assign o_tick = (cnt_q == LAST);

    always_comb begin
        cnt_d = o_tick ? '0 : cnt_q + CW'(1);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) cnt_q <= '0;
        else      cnt_q <= cnt_d;
    end

endmodule

// File: rtl/uart_rx.sv
// 8N1 receiver with 16x oversampling; o_rx_done fires ~152 ticks after the start edge.
// No backpressure: a new byte overwrites o_data whether or not it was consumed.
module uart_rx
    import uart_pkg::*;
#(
    parameter int unsigned CLK_FREQ  = 50_000_000,
    parameter int unsigned BAUD_RATE = 9600,
    parameter int unsigned DATA_BITS = 8,
    parameter int unsigned SB_TICK   = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 i_rx,
    output logic [DATA_BITS-1:0] o_data,
    output logic                 o_rx_done,
    output logic                 o_frame_err
);

    localparam int unsigned DIV = calc_div(CLK_FREQ, BAUD_RATE);
    localparam int unsigned NW  = (DATA_BITS > 1) ? $clog2(DATA_BITS) : 1;
    localparam logic [NW-1:0] N_LAST  = NW'(DATA_BITS - 1);
    localparam logic [3:0]    S_MID   = 4'd7;
    localparam logic [3:0]    S_LAST  = 4'd15;
    localparam logic [3:0]    SB_LAST = 4'(SB_TICK - 1);

    logic tick;

    baud_rate_gen #(.DIV(DIV)) u_baud (
        .clk    (clk),
        .rst    (rst),
        .o_tick (tick)
    );

    logic rx_meta_q, rx_q, rx_prev_q;
    uart_state_e state_q, state_d;
    logic [3:0]           s_q, s_d;
    logic [NW-1:0]        n_q, n_d;
    logic [DATA_BITS-1:0] b_q, b_d;
    logic [DATA_BITS-1:0] data_q, data_d;
    logic                 done_q, done_d;
    logic                 ferr_q, ferr_d;

    // Synchroniser idles high so reset release never looks like a start edge.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rx_meta_q <= 1'b1;
            rx_q      <= 1'b1;
            rx_prev_q <= 1'b1;
        end else begin
            rx_meta_q <= i_rx;
            rx_q      <= rx_meta_q;
            rx_prev_q <= rx_q;
        end
    end

    always_comb begin
        state_d = state_q;
        s_d     = s_q;
        n_d     = n_q;
        b_d     = b_q;
        data_d  = data_q;
        done_d  = 1'b0;
        ferr_d  = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (rx_prev_q && !rx_q) begin
                    s_d     = 4'd0;
                    state_d = S_START;
                end
            end
            S_START: begin
                if (tick) begin
                    if (s_q == S_MID) begin
                        if (rx_q) begin
                            state_d = S_IDLE;
                        end else begin
                            s_d     = 4'd0;
                            n_d     = '0;
                            state_d = S_DATA;
                        end
                    end else begin
                        s_d = s_q + 4'd1;
                    end
                end
            end
            S_DATA: begin
                if (tick) begin
                    if (s_q == S_LAST) begin
                        b_d = {rx_q, b_q[DATA_BITS-1:1]};
                        s_d = 4'd0;
                        if (n_q == N_LAST) state_d = S_STOP;
                        else               n_d = n_q + NW'(1);
                    end else begin
                        s_d = s_q + 4'd1;
                    end
                end
            end
            S_STOP: begin
                if (tick) begin
                    if (s_q == SB_LAST) begin
                        if (rx_q) begin
                            data_d = b_q;
                            done_d = 1'b1;
                        end else begin
                            ferr_d = 1'b1;
                        end
                        state_d = S_IDLE;
                    end else begin
                        s_d = s_q + 4'd1;
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= S_IDLE;
            s_q     <= 4'd0;
            n_q     <= '0;
            b_q     <= '0;
            data_q  <= '0;
            done_q  <= 1'b0;
            ferr_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            s_q     <= s_d;
            n_q     <= n_d;
            b_q     <= b_d;
            data_q  <= data_d;
            done_q  <= done_d;
            ferr_q  <= ferr_d;
        end
    end

    assign o_data      = data_q;
    assign o_rx_done   = done_q;
    assign o_frame_err = ferr_q;

endmodule

// File: tb/tb_uart_rx.sv
// Directed and random 8N1 frames against a byte/timing reference (DIV=10, 160 clk/bit).
module tb_uart_rx;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       i_rx = 1'b1;
    logic [7:0] o_data;
    logic       o_rx_done;
    logic       o_frame_err;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;
    int overlap = 0;

    logic [7:0] done_dat[$];
    int         done_cyc[$];
    int         err_cyc[$];

    uart_rx #(
        .CLK_FREQ  (1_600_000),
        .BAUD_RATE (10_000),
        .DATA_BITS (8),
        .SB_TICK   (16)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .i_rx        (i_rx),
        .o_data      (o_data),
        .o_rx_done   (o_rx_done),
        .o_frame_err (o_frame_err)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (o_rx_done) begin
            done_dat.push_back(o_data);
            done_cyc.push_back(cyc);
        end
        if (o_frame_err) err_cyc.push_back(cyc);
        if (o_rx_done && o_frame_err) overlap++;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic chk_rng(input string tag, input int v, input int lo, input int hi);
        total++;
        assert (v >= lo && v <= hi) else begin
            bad++;
            $error("FAIL %s observed=%0d expected=%0d..%0d", tag, v, lo, hi);
        end
    endtask

    // Byte captured by the n-th strobe, or an impossible value if it never came.
    function automatic logic [31:0] got(input int idx);
        return (done_dat.size() > idx) ? {24'h0, done_dat[idx]} : 32'hFFFF_FFFF;
    endfunction

    // Called and returns half a clock past a rising edge.
    task automatic line(input logic v, input int n);
        i_rx = v;
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic send_frame(input logic [7:0] d, input int bclk, input logic stopv,
                              output int t0);
        t0 = cyc;
        line(1'b0, bclk);
        for (int i = 0; i < 8; i++) line(d[i], bclk);
        line(stopv, bclk);
    endtask

    initial begin
        int t0, t1, t2, nd, ne, bclk, gap;
        logic [7:0] d;
        logic [7:0] pat;
        logic [7:0] exp_q[$];

        rst = 1'b0;
        i_rx = 1'b1;
        repeat (5) @(posedge clk);
        #1;
        chk("reset_data", 32'(o_data), 32'h0);
        chk("reset_done", 32'(o_rx_done), 32'h0);
        chk("reset_ferr", 32'(o_frame_err), 32'h0);
        rst = 1'b1;
        line(1'b1, 50);

        // Single byte with start-edge-to-strobe latency.
        nd = done_dat.size(); ne = err_cyc.size();
        send_frame(8'hA5, 160, 1'b1, t0);
        line(1'b1, 100);
        chk("a5_count", 32'(done_dat.size() - nd), 32'd1);
        chk("a5_byte", got(nd), 32'hA5);
        chk("a5_hold", 32'(o_data), 32'hA5);
        t1 = (done_cyc.size() > nd) ? done_cyc[nd] - t0 : -1;
        chk_rng("a5_latency", t1, 1512, 1532);
        chk("a5_ferr", 32'(err_cyc.size() - ne), 32'd0);

        // 40-clock glitch must be rejected, then a real frame accepted.
        nd = done_dat.size(); ne = err_cyc.size();
        line(1'b0, 40);
        line(1'b1, 300);
        chk("glitch_done", 32'(done_dat.size() - nd), 32'd0);
        chk("glitch_ferr", 32'(err_cyc.size() - ne), 32'd0);
        send_frame(8'h3C, 160, 1'b1, t0);
        line(1'b1, 100);
        chk("3c_count", 32'(done_dat.size() - nd), 32'd1);
        chk("3c_byte", got(nd), 32'h3C);

        // Stop bit low followed by a break: one error, data held, no retrigger.
        nd = done_dat.size(); ne = err_cyc.size();
        send_frame(8'h55, 160, 1'b0, t0);
        line(1'b0, 300);
        line(1'b1, 400);
        chk("ferr_count", 32'(err_cyc.size() - ne), 32'd1);
        chk("ferr_done", 32'(done_dat.size() - nd), 32'd0);
        chk("ferr_hold", 32'(o_data), 32'h3C);
        t1 = (err_cyc.size() > ne) ? err_cyc[ne] - t0 : -1;
        chk_rng("ferr_latency", t1, 1512, 1532);
        send_frame(8'h0F, 160, 1'b1, t0);
        line(1'b1, 100);
        chk("0f_count", 32'(done_dat.size() - nd), 32'd1);
        chk("0f_byte", got(nd), 32'h0F);

        // Zero-gap frames.
        nd = done_dat.size();
        send_frame(8'h00, 160, 1'b1, t0);
        send_frame(8'hFF, 160, 1'b1, t0);
        send_frame(8'h81, 160, 1'b1, t0);
        line(1'b1, 100);
        chk("b2b_count", 32'(done_dat.size() - nd), 32'd3);
        chk("b2b_byte0", got(nd), 32'h00);
        chk("b2b_byte1", got(nd + 1), 32'hFF);
        chk("b2b_byte2", got(nd + 2), 32'h81);
        t1 = (done_cyc.size() > nd + 1) ? done_cyc[nd + 1] - done_cyc[nd] : -1;
        t2 = (done_cyc.size() > nd + 2) ? done_cyc[nd + 2] - done_cyc[nd + 1] : -1;
        chk_rng("b2b_gap01", t1, 1590, 1610);
        chk_rng("b2b_gap12", t2, 1590, 1610);

        // Reset after data bit 3 of 0x96; released while the tail is high.
        nd = done_dat.size(); ne = err_cyc.size();
        pat = 8'h96;
        line(1'b0, 160);
        for (int i = 0; i < 4; i++) line(pat[i], 160);
        rst = 1'b0;
        #2;
        chk("rstmid_data", 32'(o_data), 32'h0);
        chk("rstmid_done", 32'(o_rx_done), 32'h0);
        chk("rstmid_ferr", 32'(o_frame_err), 32'h0);
        for (int i = 4; i < 7; i++) line(pat[i], 160);
        line(pat[7], 80);
        chk("rstlate_data", 32'(o_data), 32'h0);
        rst = 1'b1;
        line(pat[7], 80);
        line(1'b1, 400);
        chk("abort_done", 32'(done_dat.size() - nd), 32'd0);
        chk("abort_ferr", 32'(err_cyc.size() - ne), 32'd0);
        send_frame(8'h42, 160, 1'b1, t0);
        line(1'b1, 100);
        chk("42_count", 32'(done_dat.size() - nd), 32'd1);
        chk("42_byte", got(nd), 32'h42);

        // +/-3% bit period.
        nd = done_dat.size();
        send_frame(8'hC3, 155, 1'b1, t0);
        line(1'b1, 300);
        send_frame(8'hC3, 165, 1'b1, t0);
        line(1'b1, 300);
        chk("tol_count", 32'(done_dat.size() - nd), 32'd2);
        chk("tol_fast", got(nd), 32'hC3);
        chk("tol_slow", got(nd + 1), 32'hC3);

        // Random bytes, slight rate skew, random idle gaps.
        nd = done_dat.size(); ne = err_cyc.size();
        for (int k = 0; k < 8; k++) begin
            d    = 8'($urandom_range(0, 255));
            bclk = int'($urandom_range(157, 163));
            gap  = int'($urandom_range(0, 100));
            exp_q.push_back(d);
            send_frame(d, bclk, 1'b1, t0);
            line(1'b1, gap);
        end
        line(1'b1, 200);
        chk("rnd_count", 32'(done_dat.size() - nd), 32'(exp_q.size()));
        chk("rnd_ferr", 32'(err_cyc.size() - ne), 32'd0);
        for (int k = 0; k < exp_q.size(); k++)
            chk($sformatf("rnd_byte%0d", k), got(nd + k), {24'h0, exp_q[k]});
        chk("rnd_hold", 32'(o_data), {24'h0, exp_q[exp_q.size() - 1]});

        chk("no_overlap", 32'(overlap), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/uart_rx.md
# uart_rx

UART receiver for 8N1 serial frames on the board's RX pin. Sits directly upstream of the debugger: delivers each received byte on `o_data` with a one-cycle `o_rx_done` strobe, which feed the debugger's `i_data`/`i_rx_done` inputs. The host uses this path to send commands and program words to the MIPS core. Includes input synchronisation, 16x oversampling, false-start rejection and framing-error detection.

## Interface
- `CLK_FREQ`, 50_000_000: system clock frequency in Hz.
- `BAUD_RATE`, 9600: line rate in bit/s.
- `DATA_BITS`, 8: data bits per frame; LSB first.
- `SB_TICK`, 16: oversample ticks in the stop bit.
- `clk`  input  1  system clock; all logic on the rising edge.
- `rst`  input  1  asynchronous, active-low reset.
- `i_rx`  input  1  raw serial line; idle high; asynchronous to `clk`.
- `o_data`  output  DATA_BITS  last correctly received byte; holds until the next good frame.
- `o_rx_done`  output  1  one-cycle pulse; `o_data` is valid in the same cycle.
- `o_frame_err`  output  1  one-cycle pulse when the stop bit samples low.

## Operation
- **Synchroniser:** two-flop synchroniser on `i_rx`; both flops reset to 1. An extra flop `rx_prev` stores the previous synchronised value for edge detection.
- **Tick generator:** the divisor is DIV = CLK_FREQ/(BAUD_RATE*16), using integer floor.
  - The counter runs from 0 to DIV-1 and free-runs from reset.
  - `tick` is high for one cycle when the counter equals DIV-1.
- **FSM states:** IDLE, START, DATA, STOP. The tick counter `s` is 4 bits, the bit counter `n` is log2(DATA_BITS) bits, and the shift register `b` is DATA_BITS wide.
- **IDLE:**
  - Triggers on a synchronised falling edge (rx_prev=1, rx=0).
  - On the trigger: `s`←0, then go to START.
- **START:**
  - `s` increments on each tick.
  - At a tick with s==7, sample rx:
    - rx=1: false start; return to IDLE.
    - rx=0: `s`←0, `n`←0, go to DATA.
- **DATA:**
  - At a tick with s==15: `b`←{rx, b[DATA_BITS-1:1]} and `s`←0.
  - If n==DATA_BITS-1, go to STOP; otherwise `n`++.
  - On other ticks, `s`++.
- **STOP:**
  - At a tick with s==SB_TICK-1, sample rx:
    - rx=1: `o_data`←b, pulse `o_rx_done`.
    - rx=0: pulse `o_frame_err`; `o_data` is unchanged.
  - In both cases return to IDLE.
- **Framing error recovery:** a line held low (break) does not retrigger. IDLE needs a fresh falling edge, so the line must go high first.
- Edges of `i_rx` outside IDLE are ignored.
- `o_rx_done` and `o_frame_err` are never high in the same cycle.

## Timing
- **Reset values:** `o_data`=0, `o_rx_done`=0, `o_frame_err`=0, FSM=IDLE, counters=0, synchroniser=1.
- Reset mid-frame aborts immediately, with no strobe. A partial frame still on the line after release is ignored until the next falling edge.
- **Input latency:** 2 cycles from `i_rx` to the synchronised value, plus 1 cycle for edge detection.
- **Frame latency:** `o_rx_done` fires 8 + 16*DATA_BITS + SB_TICK ticks after the synchronised falling edge. That is 152 ticks, i.e. the middle of the stop bit, with ±1 tick of phase uncertainty from the free-running divider.
- **Back-to-back frames:** the receiver is back in IDLE half a stop bit before the line's next start edge. Zero-gap frames are received without loss.
- **Output holding:** `o_data` changes only in the `o_rx_done` cycle. The downstream consumer may sample it at any time after the strobe.
- No backpressure. A byte is overwritten if the next frame completes before the consumer reads it.

## Structure
- **Package `uart_pkg`:** FSM state enum, and the function computing DIV from CLK_FREQ/BAUD_RATE.
  - The same package serves the matching transmitter.
- **Sub-module `baud_rate_gen`:** parameter DIV; ports clk, rst, o_tick.
  - Shared with `uart_tx`.
- `uart_rx` contains the synchroniser, the FSM and the output registers.

## Test plan
- **Bench setup:** all scenarios use CLK_FREQ=1_600_000 and BAUD_RATE=10_000, giving DIV=10 and 160 clocks per bit.
- **Single byte:** drive 0xA5 at 160 clk/bit → one `o_rx_done` pulse 1522±10 clks after the start edge; `o_data`=0xA5; `o_frame_err` stays 0.
- **False start:** 40-clk low glitch on idle line → no strobes; FSM back in IDLE; a following 0x3C frame is received correctly.
- **Framing error:** 0x55 frame with stop bit held low, then line high → `o_frame_err` pulses once, `o_rx_done` stays 0, `o_data` keeps its previous value. A subsequent 0x0F frame is received correctly.
- **Back-to-back:** 0x00, 0xFF, 0x81 with no idle gap → three `o_rx_done` pulses, 1600±10 clks apart, carrying those values in order.
- **Reset mid-frame:** assert `rst` low after bit 3 of 0x96, release it, then send 0x42 → no strobe for the aborted frame; next strobe carries 0x42. All outputs read 0 while in reset.
- **Baud tolerance:** 0xC3 sent at ±3% bit period (155 and 165 clks/bit) → received correctly in both cases.
